// File: rtl/br_unit.sv
// br_unit: branch target unit with a circular return-address stack.
//   clk, rst_f             clock and asynchronous active-low reset
//   br_req, br_mode        request valid; 00 REL, 01 ABS, 10 CALL, 11 RET
//   cond_taken             branch condition from the status logic
//   pc_inc, imm            PC+1 of the branch and its immediate
//   ras_flush, err_clr     empty the stack; clear the sticky error flags
//   br_valid, br_take      one-cycle result pulse; PC should load br_addr
//   br_addr                registered target address
//   ras_empty, ras_full    stack occupancy decoded from the registered count
//   ras_ovf, ras_udf       sticky push-while-full / pop-while-empty flags
module br_unit #(
    parameter int AW        = 16,
    parameter int IW        = 16,
    parameter bit SEXT      = 1'b1,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          br_req,
    input  logic [1:0]    br_mode,
    input  logic          cond_taken,
    input  logic [AW-1:0] pc_inc,
    input  logic [IW-1:0] imm,
    input  logic          ras_flush,
    input  logic          err_clr,
    output logic          br_valid,
    output logic          br_take,
    output logic [AW-1:0] br_addr,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_ovf,
    output logic          ras_udf
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] TOP_MAX = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

    logic [AW-1:0] stack_q [RAS_DEPTH];
    logic [PW-1:0] top_q, top_d, top_inc, top_dec;
    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    logic [AW-1:0] br_addr_q, br_addr_d, ext, target;
    logic          br_valid_q, br_valid_d, br_take_q, br_take_d;
    logic          ras_ovf_q, ras_ovf_d, ras_udf_q, ras_udf_d;
    logic          taken, eff_empty, push, pop, ovf_ev, udf_ev;

    always_comb begin
        ext       = SEXT ? AW'($signed(imm)) : AW'(imm);
        taken     = br_req & cond_taken;
        // flush takes effect before this cycle's stack operation
        cnt_eff   = ras_flush ? '0 : cnt_q;
        eff_empty = (cnt_eff == '0);
        top_inc   = (top_q == TOP_MAX) ? '0 : top_q + PW'(1);
        top_dec   = (top_q == '0) ? TOP_MAX : top_q - PW'(1);
        push      = taken & (br_mode == 2'b10);
        pop       = taken & (br_mode == 2'b11) & ~eff_empty;
        ovf_ev    = push & (cnt_eff == CNT_MAX);
        udf_ev    = taken & (br_mode == 2'b11) & eff_empty;
        // an empty stack has no return target, so RET falls through
        target    = (br_mode == 2'b00) ? pc_inc + ext :
                    (br_mode == 2'b11) ? (eff_empty ? pc_inc : stack_q[top_q]) : ext;
        br_valid_d = br_req;
        br_take_d  = taken & ~udf_ev;
        br_addr_d  = br_req ? target : br_addr_q;
        // a full push overwrites the oldest entry, so the count saturates
        cnt_d      = push ? (ovf_ev ? cnt_eff : cnt_eff + CW'(1)) :
                     pop  ? cnt_eff - CW'(1) : cnt_eff;
        top_d      = push ? top_inc : pop ? top_dec : top_q;
        ras_ovf_d  = ovf_ev | (ras_ovf_q & ~err_clr);
        ras_udf_d  = udf_ev | (ras_udf_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            br_valid_q <= 1'b0;
            br_take_q  <= 1'b0;
            br_addr_q  <= '0;
            cnt_q      <= '0;
            top_q      <= '0;
            ras_ovf_q  <= 1'b0;
            ras_udf_q  <= 1'b0;
        end else begin
            br_valid_q <= br_valid_d;
            br_take_q  <= br_take_d;
            br_addr_q  <= br_addr_d;
            cnt_q      <= cnt_d;
            top_q      <= top_d;
            ras_ovf_q  <= ras_ovf_d;
            ras_udf_q  <= ras_udf_d;
        end
    end

    // entry contents are don't-care until pushed, so they carry no reset
    always_ff @(posedge clk) begin
        if (push) stack_q[top_d] <= pc_inc;
    end

    assign br_valid  = br_valid_q;
    assign br_take   = br_take_q;
    assign br_addr   = br_addr_q;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_MAX);
    assign ras_ovf   = ras_ovf_q;
    assign ras_udf   = ras_udf_q;
endmodule

// File: tb/tb_br_unit.sv
// tb_br_unit: directed and random checks of br_unit against a queue-based stack model.
module tb_br_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst_f = 1'b1, br_req = 1'b0, cond_taken = 1'b0;
    logic        ras_flush = 1'b0, err_clr = 1'b0;
    logic [1:0]  br_mode = 2'b00;
    logic [15:0] pc_inc = '0, imm = '0;
    logic        br_valid, br_take, ras_empty, ras_full, ras_ovf, ras_udf;
    logic [15:0] br_addr;

    br_unit dut (
        .clk(clk), .rst_f(rst_f), .br_req(br_req), .br_mode(br_mode),
        .cond_taken(cond_taken), .pc_inc(pc_inc), .imm(imm),
        .ras_flush(ras_flush), .err_clr(err_clr), .br_valid(br_valid),
        .br_take(br_take), .br_addr(br_addr), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_udf(ras_udf)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_err = 0;
    logic [15:0] stk[$];
    logic [15:0] m_addr;
    bit          m_valid, m_take, m_ovf, m_udf, addr_known;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_valid = 0; m_take = 0; m_addr = '0; m_ovf = 0; m_udf = 0; addr_known = 1;
    endtask

    task automatic model_step();
        logic [15:0] tgt;
        bit taken, ovf_ev, udf_ev;
        ovf_ev = 0;
        udf_ev = 0;
        tgt = m_addr;
        if (ras_flush) stk.delete();
        taken = br_req && cond_taken;
        if (br_req) begin
            addr_known = 1;
            case (br_mode)
                2'b00: tgt = pc_inc + imm;
                2'b01, 2'b10: tgt = imm;
                default: begin
                    if (stk.size() == 0) begin
                        tgt = pc_inc;
                        udf_ev = taken;
                        addr_known = taken;
                    end else tgt = stk[$];
                end
            endcase
            if (taken && br_mode == 2'b10) begin
                if (stk.size() == DEPTH) begin
                    void'(stk.pop_front());
                    ovf_ev = 1;
                end
                stk.push_back(pc_inc);
            end
            if (taken && br_mode == 2'b11 && !udf_ev) void'(stk.pop_back());
        end
        m_valid = br_req;
        m_take  = taken && !udf_ev;
        m_addr  = tgt;
        m_ovf   = ovf_ev || (m_ovf && !err_clr);
        m_udf   = udf_ev || (m_udf && !err_clr);
    endtask

    task automatic check_outs(string tag);
        check({tag, "_valid"}, br_valid, m_valid);
        check({tag, "_take"}, br_take, m_take);
        if (addr_known) check({tag, "_addr"}, br_addr, m_addr);
        check({tag, "_empty"}, ras_empty, stk.size() == 0);
        check({tag, "_full"}, ras_full, stk.size() == DEPTH);
        check({tag, "_ovf"}, ras_ovf, m_ovf);
        check({tag, "_udf"}, ras_udf, m_udf);
    endtask

    task automatic cyc(string tag, bit req, logic [1:0] mode, bit cond, logic [15:0] pc,
                       logic [15:0] im, bit fl = 0, bit clr = 0);
        br_req = req; br_mode = mode; cond_taken = cond; pc_inc = pc; imm = im;
        ras_flush = fl; err_clr = clr;
        @(posedge clk);
        model_step();
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset(string tag);
        br_req = 0; ras_flush = 0; err_clr = 0;
        rst_f = 1'b0;
        #1;
        check({tag, "_valid"}, br_valid, 0);
        check({tag, "_take"}, br_take, 0);
        check({tag, "_addr"}, br_addr, 0);
        check({tag, "_empty"}, ras_empty, 1);
        check({tag, "_full"}, ras_full, 0);
        check({tag, "_ovf"}, ras_ovf, 0);
        check({tag, "_udf"}, ras_udf, 0);
        model_reset();
        #1 rst_f = 1'b1;
    endtask

    initial begin
        model_reset();
        #12 do_reset("rst0");

        cyc("rel", 1, 2'b00, 1, 16'h0010, 16'hFFFE);
        check("rel_spec", br_addr, 16'h000E);
        cyc("abs", 1, 2'b01, 1, 16'h0000, 16'h1234);
        check("abs_spec", br_addr, 16'h1234);
        cyc("relwrap", 1, 2'b00, 1, 16'hFFFF, 16'h0002);
        check("relwrap_spec", br_addr, 16'h0001);
        cyc("idle", 0, 2'b00, 1, 16'h5555, 16'h5555);

        for (int i = 1; i <= 3; i++) cyc("call", 1, 2'b10, 1, 16'(16'h0101 * i), 16'h0400);
        for (int i = 3; i >= 1; i--) begin
            cyc("ret", 1, 2'b11, 1, 16'h0500, 16'h0000);
            check("ret_spec", br_addr, 16'(16'h0101 * i));
        end
        check("nest_empty", ras_empty, 1);

        for (int i = 0; i < 5; i++) cyc("ovcall", 1, 2'b10, 1, 16'(16'h00A0 + i), 16'h0040);
        check("ov_full", ras_full, 1);
        check("ov_flag", ras_ovf, 1);
        for (int i = 4; i >= 1; i--) begin
            cyc("ovret", 1, 2'b11, 1, 16'h0600, 16'h0000);
            check("ovret_spec", br_addr, 16'(16'h00A0 + i));
        end
        cyc("udf", 1, 2'b11, 1, 16'h0777, 16'h0000);
        check("udf_addr", br_addr, 16'h0777);
        check("udf_take", br_take, 0);
        check("udf_flag", ras_udf, 1);
        cyc("clr", 0, 2'b00, 0, 16'h0000, 16'h0000, 0, 1);
        check("clr_flags", {ras_ovf, ras_udf}, 2'b00);

        cyc("ntcall", 1, 2'b10, 0, 16'h0111, 16'h0222);
        check("ntcall_take", br_take, 0);
        check("ntcall_empty", ras_empty, 1);
        cyc("call2", 1, 2'b10, 1, 16'h0121, 16'h0300);
        cyc("call2", 1, 2'b10, 1, 16'h0131, 16'h0300);
        cyc("retfl", 1, 2'b11, 1, 16'h0888, 16'h0000, 1, 0);
        check("retfl_addr", br_addr, 16'h0888);
        check("retfl_take", br_take, 0);
        check("retfl_empty", ras_empty, 1);
        check("retfl_udf", ras_udf, 1);
        cyc("clr2", 0, 2'b00, 0, 16'h0000, 16'h0000, 0, 1);

        for (int i = 0; i < 3; i++) cyc("rcall", 1, 2'b10, 1, 16'(16'h0C00 + i), 16'h0010);
        do_reset("rstmid");
        cyc("rret", 1, 2'b11, 1, 16'h0999, 16'h0000);
        check("rret_addr", br_addr, 16'h0999);
        check("rret_udf", ras_udf, 1);

        for (int i = 0; i < 3000; i++)
            cyc("rnd", $urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 3) != 0,
                16'($urandom), 16'($urandom), $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
